// File: rtl/vector_pkg.sv
// Shared constants, types and helpers for the vector unpacker.
// Frame layout: {a, b, c, d, e, f, 2'b11}, most-significant byte first.
package vector_pkg;

    localparam int FIELD_W         = 5;
    localparam int NUM_FIELDS      = 6;
    localparam int BYTES_PER_FRAME = 4;
    localparam int FRAME_W         = 32;
    localparam int IDX_W           = $clog2(BYTES_PER_FRAME);

    localparam logic [1:0] TRAILER = 2'b11;

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] a;
        logic [FIELD_W-1:0] b;
        logic [FIELD_W-1:0] c;
        logic [FIELD_W-1:0] d;
        logic [FIELD_W-1:0] e;
        logic [FIELD_W-1:0] f;
    } fields_t;

    // Split a completed word into its six fields, dropping the trailer.
    function automatic fields_t unpack_frame(
        input logic [FRAME_W-1:0] w
    );
        fields_t r;
        r = w[FRAME_W-1:2];
        return r;
    endfunction

endpackage

// File: rtl/vector_byte_collector.sv
// Byte shift register plus byte index; flags the beat that completes a frame.
// frame shows the word as it will be after the current beat is shifted in.
module vector_byte_collector
    import vector_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               beat,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_done
);

    logic [FRAME_W-1:0] shift_q;
    logic [IDX_W-1:0]   idx_q;

    assign frame      = {shift_q[FRAME_W-9:0], in_data};
    assign frame_done = beat && (idx_q == IDX_W'(BYTES_PER_FRAME - 1));

    // Shift each accepted byte in and advance the index; it wraps after byte 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (beat) begin
            shift_q <= frame;
            idx_q   <= frame_done ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/vector_unpacker.sv
// Receives 4-byte packed frames and presents six 5-bit fields on valid/ready.
// VECTOR_UNPACK_CHECK_EN: drop bad-trailer frames and count them in err_cnt.
module vector_unpacker
    import vector_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FIELD_W-1:0]   a,
    output logic [FIELD_W-1:0]   b,
    output logic [FIELD_W-1:0]   c,
    output logic [FIELD_W-1:0]   d,
    output logic [FIELD_W-1:0]   e,
    output logic [FIELD_W-1:0]   f,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t             state_q;
    state_t             state_d;
    fields_t            fields_q;
    logic [FRAME_W-1:0] frame;
    logic               frame_done;
    logic               beat;
    logic               accept_frame;

    // Both handshake outputs come straight from the state register.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign beat      = in_valid && in_ready;

    vector_byte_collector u_collector (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .beat       (beat),
        .frame      (frame),
        .frame_done (frame_done)
    );

`ifdef VECTOR_UNPACK_CHECK_EN
    logic                 trailer_ok;
    logic [ERR_CNT_W-1:0] err_q;

    assign trailer_ok   = (frame[1:0] == TRAILER);
    assign accept_frame = frame_done && trailer_ok;
    assign err_cnt      = err_q;

    // Count dropped frames, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (frame_done && !trailer_ok && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end
`else
    logic unused_trailer;

    assign unused_trailer = ^frame[1:0];
    assign accept_frame   = frame_done;
    assign err_cnt        = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: hold a decoded frame until the consumer takes it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (accept_frame) state_d = HOLD;
            HOLD:    if (out_ready)    state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Latch fields on the completing beat; stable through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fields_q <= '0;
        end else if (accept_frame) begin
            fields_q <= unpack_frame(frame);
        end
    end

    assign a = fields_q.a;
    assign b = fields_q.b;
    assign c = fields_q.c;
    assign d = fields_q.d;
    assign e = fields_q.e;
    assign f = fields_q.f;

endmodule
